// File: rtl/slow_clk_pkg.sv
// Shared constants and helpers for the slow clock divider.
// Default half period gives a 1 Hz square wave from a 50 MHz system clock.
package slow_clk_pkg;

   localparam int SLOW_CLK_DEFAULT_HALF_PERIOD = 25_000_000;

   // Counter width for a modulo-N count; never narrower than one bit.
   function automatic int cnt_width(input int half_period);
      int w;
      w = $clog2(half_period);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/slow_clk_div_counter.sv
// Modulo-N up counter with synchronous active-high reset and a terminal-count wrap strobe.
// The count runs 0..MODULUS-1 and returns to 0, so it never overflows its width.
module mod_counter
   import slow_clk_pkg::*;
#(
   parameter int MODULUS = 2,
   parameter int WIDTH   = cnt_width(MODULUS)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic wrap
);

   logic [WIDTH-1:0] cnt;

   assign wrap = en && (cnt == WIDTH'(MODULUS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         if (wrap) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/slow_clk_div.sv
// Divides clk into a registered 50%-duty square wave, HALF_PERIOD clk cycles per half.
// Optional macro SLOW_CLK_TICK_EN adds a one-cycle strobe on each slow_clk rise.
module slow_clk_div
   import slow_clk_pkg::*;
#(
   parameter int HALF_PERIOD = SLOW_CLK_DEFAULT_HALF_PERIOD
) (
   input  logic clk,
   input  logic rst,
   output logic slow_clk
`ifdef SLOW_CLK_TICK_EN
   ,
   output logic tick
`endif
);

   generate
      if (HALF_PERIOD < 1) begin : g_bad_half_period
         $error("slow_clk_div: HALF_PERIOD must be at least 1");
      end
   endgenerate

   logic wrap;

   mod_counter #(
      .MODULUS (HALF_PERIOD)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (1'b1),
      .wrap (wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         slow_clk <= 1'b0;
      end else if (wrap) begin
         slow_clk <= ~slow_clk;
      end
   end

`ifdef SLOW_CLK_TICK_EN
   // A wrap while slow_clk is low is exactly the 0->1 toggle, so tick lands with the rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick <= 1'b0;
      end else begin
         tick <= wrap & ~slow_clk;
      end
   end
`endif

endmodule

// File: tb/tb_slow_clk_div.sv
// Scoreboard bench for slow_clk_div: five instances with different HALF_PERIOD values
// share one clock; stimulus queues expected outputs, a negedge monitor compares them.
module tb_slow_clk_div;

   localparam int N_DUT = 5;

   function automatic int hp_of(input int i);
      case (i)
         0:       return 2;
         1:       return 5;
         2:       return 1;
         3:       return 4;
         default: return 3;
      endcase
   endfunction

   typedef struct {
      int    cyc;
      int    dut;
      logic  slow;
      logic  tick;
      string name;
   } exp_t;

   logic             clk = 1'b0;
   logic [N_DUT-1:0] rst;
   logic [N_DUT-1:0] slow;
`ifdef SLOW_CLK_TICK_EN
   logic [N_DUT-1:0] tick;
`endif

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      slow_clk_div #(
         .HALF_PERIOD (hp_of(g))
      ) u_dut (
         .clk      (clk),
         .rst      (rst[g]),
         .slow_clk (slow[g])
`ifdef SLOW_CLK_TICK_EN
         ,
         .tick     (tick[g])
`endif
      );
   end

   task automatic expect_at(input int c, input int d, input logic s, input logic t,
                            input string nm);
      exp_t e;
      e.cyc  = c;
      e.dut  = d;
      e.slow = s;
      e.tick = t;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every queued expectation whose cycle has arrived.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            checks = checks + 1;
            if (sb[i].cyc < cyc) begin
               errors = errors + 1;
               $display("FAIL %s dut%0d: expectation for cycle %0d missed at cycle %0d",
                        sb[i].name, sb[i].dut, sb[i].cyc, cyc);
            end else if (slow[sb[i].dut] !== sb[i].slow) begin
               errors = errors + 1;
               $display("FAIL %s dut%0d cycle %0d: slow_clk=%b expected %b",
                        sb[i].name, sb[i].dut, cyc, slow[sb[i].dut], sb[i].slow);
            end
`ifdef SLOW_CLK_TICK_EN
            checks = checks + 1;
            if (tick[sb[i].dut] !== sb[i].tick) begin
               errors = errors + 1;
               $display("FAIL %s_tick dut%0d cycle %0d: tick=%b expected %b",
                        sb[i].name, sb[i].dut, cyc, tick[sb[i].dut], sb[i].tick);
            end
`endif
            sb.delete(i);
         end
      end
   end

   initial begin
      int   base;
      logic s2 [6];
      logic t2 [6];
      s2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      t2 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset held over two edges: every instance stays low.
      rst = '1;
      for (int d = 0; d < N_DUT; d++) begin
         for (int e = 1; e <= 2; e++) expect_at(e, d, 1'b0, 1'b0, "reset_hold");
      end
      step();
      step();

      base = cyc;
      rst  = '0;

      // HALF_PERIOD=2: first toggle after the second edge, then every two edges.
      for (int n = 1; n <= 6; n++) expect_at(base + n, 0, s2[n-1], t2[n-1], "first_toggle");

      // HALF_PERIOD=1: divide-by-2, rising on the very first edge.
      for (int n = 1; n <= 6; n++)
         expect_at(base + n, 2, logic'(n % 2), logic'(n % 2), "div2");

      // HALF_PERIOD=5: 100 edges, runs of exactly five, rise every ten.
      for (int n = 1; n <= 100; n++)
         expect_at(base + n, 1, logic'((n / 5) % 2), logic'(n % 10 == 5), "steady_hp5");

      // HALF_PERIOD=3: one tick per six cycles, only on rises.
      for (int n = 1; n <= 60; n++)
         expect_at(base + n, 4, logic'((n / 3) % 2), logic'(n % 6 == 3), "tick_hp3");

      // HALF_PERIOD=4: high from edge 4; after edge 6 the count is 2.
      for (int n = 1; n <= 6; n++)
         expect_at(base + n, 3, logic'((n / 4) % 2), logic'(n == 4), "pre_reset");

      for (int k = 0; k < 6; k++) step();
      rst[3] = 1'b1;
      expect_at(base + 7, 3, 1'b0, 1'b0, "mid_reset");
      step();
      rst[3] = 1'b0;
      for (int m = 1; m <= 8; m++)
         expect_at(base + 7 + m, 3, logic'(m >= 4 && m <= 7), logic'(m == 4), "after_reset");

      for (int k = 0; k < 300 && sb.size() != 0; k++) step();
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d expectations still queued, required 0", sb.size());
         checks = checks + sb.size();
         errors = errors + sb.size();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
